// File: rtl/ulpb_tx_arbiter_if.sv
// Bus bundle between the LC requesters, the TX arbiter and the ulpb node TX port.
// slave = arbiter view, master = requester/node environment view.
interface ulpb_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ID_DEPTH   = 8
);
    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]            REQ_ACK;
    logic [ADDR_WIDTH-1:0]         NODE_ADDR;
    logic [DATA_WIDTH-1:0]         NODE_DATA;
    logic                          NODE_REQ;
    logic                          NODE_ACK;
    logic                          NODE_TX_SUCCESS;
    logic                          NODE_TX_FAIL;
    logic                          NODE_TX_ACK;
    logic [NUM_REQ-1:0]            DONE_SUCCESS;
    logic [NUM_REQ-1:0]            DONE_FAIL;
    logic [NUM_REQ-1:0]            DONE_ACK;
    logic [$clog2(ID_DEPTH+1)-1:0] IN_FLIGHT;
    logic                          ERR_ORPHAN;

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_DATA, NODE_ACK, NODE_TX_SUCCESS, NODE_TX_FAIL, DONE_ACK,
        output REQ_ACK, NODE_ADDR, NODE_DATA, NODE_REQ, NODE_TX_ACK, DONE_SUCCESS, DONE_FAIL,
               IN_FLIGHT, ERR_ORPHAN
    );

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_DATA, NODE_ACK, NODE_TX_SUCCESS, NODE_TX_FAIL, DONE_ACK,
        input  REQ_ACK, NODE_ADDR, NODE_DATA, NODE_REQ, NODE_TX_ACK, DONE_SUCCESS, DONE_FAIL,
               IN_FLIGHT, ERR_ORPHAN
    );
endinterface

// File: rtl/ulpb_tx_arbiter.sv
// Round-robin arbiter sharing one ulpb node TX port among NUM_REQ requesters; an in-order
// ID FIFO routes each node completion back to the requester whose message it belongs to.
module ulpb_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ID_DEPTH   = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    ulpb_tx_arbiter_if.slave bus
);
    localparam int          ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          PTR_W   = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;
    localparam int          CNT_W   = $clog2(ID_DEPTH + 1);
    localparam int unsigned NREQ_U  = NUM_REQ;
    localparam int unsigned DEPTH_U = ID_DEPTH;

    typedef enum logic [1:0] {I_IDLE, I_ISSUE, I_REL} issue_state_t;
    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_REL} cpl_state_t;

    issue_state_t          i_state, i_state_d;
    cpl_state_t            c_state, c_state_d;

    logic [ID_W-1:0]       grant, grant_d, last, last_d;
    logic [ADDR_WIDTH-1:0] node_addr, node_addr_d;
    logic [DATA_WIDTH-1:0] node_data, node_data_d;
    logic                  node_req, node_req_d;
    logic [NUM_REQ-1:0]    req_ack, req_ack_d;

    logic [ID_W-1:0]       head, head_d;
    logic [NUM_REQ-1:0]    done_s, done_s_d, done_f, done_f_d;
    logic                  tx_ack, tx_ack_d, orphan, orphan_d;

    logic [ID_W-1:0]       fifo_mem [ID_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push, pop, fifo_full, fifo_empty;

    logic                  found;
    logic [ID_W-1:0]       pick;

    assign fifo_full  = (count == CNT_W'(ID_DEPTH));
    assign fifo_empty = (count == '0);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scan starting just after the last accepted requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            if (!found && bus.REQ_VALID[(32'(last) + k) % NREQ_U]) begin
                found = 1'b1;
                pick  = ID_W'((32'(last) + k) % NREQ_U);
            end
        end
    end

    always_comb begin
        i_state_d   = i_state;
        grant_d     = grant;
        last_d      = last;
        node_addr_d = node_addr;
        node_data_d = node_data;
        node_req_d  = node_req;
        req_ack_d   = req_ack;
        push        = 1'b0;
        case (i_state)
            I_IDLE: begin
                if (found && !fifo_full) begin
                    grant_d     = pick;
                    node_addr_d = bus.REQ_ADDR[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    node_data_d = bus.REQ_DATA[pick*DATA_WIDTH +: DATA_WIDTH];
                    node_req_d  = 1'b1;
                    i_state_d   = I_ISSUE;
                end
            end
            I_ISSUE: begin
                if (bus.NODE_ACK) begin
                    push             = 1'b1;
                    last_d           = grant;
                    node_req_d       = 1'b0;
                    req_ack_d[grant] = 1'b1;
                    i_state_d        = I_REL;
                end
            end
            I_REL: begin
                if (!bus.NODE_ACK && !bus.REQ_VALID[grant]) begin
                    req_ack_d = '0;
                    i_state_d = I_IDLE;
                end
            end
            default: i_state_d = I_IDLE;
        endcase
    end

    always_comb begin
        c_state_d = c_state;
        head_d    = head;
        done_s_d  = done_s;
        done_f_d  = done_f;
        tx_ack_d  = tx_ack;
        orphan_d  = orphan;
        pop       = 1'b0;
        case (c_state)
            C_IDLE: begin
                if (bus.NODE_TX_SUCCESS || bus.NODE_TX_FAIL) begin
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        head_d = fifo_mem[rd_ptr];
                        if (bus.NODE_TX_FAIL) done_f_d[fifo_mem[rd_ptr]] = 1'b1;
                        else                  done_s_d[fifo_mem[rd_ptr]] = 1'b1;
                        c_state_d = C_WAIT;
                    end else begin
                        orphan_d  = 1'b1;
                        tx_ack_d  = 1'b1;
                        c_state_d = C_REL;
                    end
                end
            end
            C_WAIT: begin
                if (bus.DONE_ACK[head]) begin
                    done_s_d  = '0;
                    done_f_d  = '0;
                    tx_ack_d  = 1'b1;
                    c_state_d = C_REL;
                end
            end
            C_REL: begin
                if (!bus.NODE_TX_SUCCESS && !bus.NODE_TX_FAIL) begin
                    tx_ack_d  = 1'b0;
                    c_state_d = C_IDLE;
                end
            end
            default: c_state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            i_state   <= I_IDLE;
            grant     <= '0;
            last      <= ID_W'(NUM_REQ - 1);
            node_addr <= '0;
            node_data <= '0;
            node_req  <= 1'b0;
            req_ack   <= '0;
        end else begin
            i_state   <= i_state_d;
            grant     <= grant_d;
            last      <= last_d;
            node_addr <= node_addr_d;
            node_data <= node_data_d;
            node_req  <= node_req_d;
            req_ack   <= req_ack_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            c_state <= C_IDLE;
            head    <= '0;
            done_s  <= '0;
            done_f  <= '0;
            tx_ack  <= 1'b0;
            orphan  <= 1'b0;
        end else begin
            c_state <= c_state_d;
            head    <= head_d;
            done_s  <= done_s_d;
            done_f  <= done_f_d;
            tx_ack  <= tx_ack_d;
            orphan  <= orphan_d;
        end
    end

    // Simultaneous push and pop both take effect and leave occupancy unchanged.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH_U; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= grant;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign bus.REQ_ACK      = req_ack;
    assign bus.NODE_ADDR    = node_addr;
    assign bus.NODE_DATA    = node_data;
    assign bus.NODE_REQ     = node_req;
    assign bus.NODE_TX_ACK  = tx_ack;
    assign bus.DONE_SUCCESS = done_s;
    assign bus.DONE_FAIL    = done_f;
    assign bus.IN_FLIGHT    = count;
    assign bus.ERR_ORPHAN   = orphan;
endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Self-checking bench for ulpb_tx_arbiter: vector table for single grants plus hand-written
// sequences for round-robin, FIFO full, orphan completion and mid-handshake reset.
module tb_ulpb_tx_arbiter;
    localparam int NR  = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int DEP = 8;

    typedef struct {
        logic [NR-1:0] valid;
        logic [1:0]    exp_id;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic          fail;
    } vec_t;

    typedef struct {
        logic [1:0]    id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } grant_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   errors = 0;

    grant_t     grant_q[$];
    logic [1:0] done_q[$];
    vec_t       tbl[6];

    always #5 CLK = ~CLK;

    ulpb_tx_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_DEPTH(DEP)) bus ();

    ulpb_tx_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_DEPTH(DEP)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    function automatic logic [AW-1:0] addr_of(input int i);
        return (i == 2) ? 8'h5A : 8'h10 + 8'(i);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return (i == 2) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {5'd0, bus.REQ_ACK, bus.NODE_ADDR, bus.NODE_DATA, bus.NODE_REQ, bus.NODE_TX_ACK,
                bus.DONE_SUCCESS, bus.DONE_FAIL, bus.IN_FLIGHT, bus.ERR_ORPHAN};
    endfunction

    // Scrambled requester buses let us see that NODE_ADDR/NODE_DATA are latched copies.
    task automatic drive_req_bus(input logic scramble);
        for (int i = 0; i < NR; i++) begin
            bus.REQ_ADDR[i*AW +: AW] = scramble ? ~addr_of(i) : addr_of(i);
            bus.REQ_DATA[i*DW +: DW] = scramble ? ~data_of(i) : data_of(i);
        end
    endtask

    task automatic expect_grant(input int id);
        grant_q.push_back('{2'(id), addr_of(id), data_of(id)});
    endtask

    task automatic wait_node_req(output int waited);
        waited = 0;
        while (bus.NODE_REQ !== 1'b1 && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        if (bus.NODE_REQ !== 1'b1) chk("node_req_timeout", 64'(bus.NODE_REQ), 64'd1);
    endtask

    task automatic serve_issue(input logic keep, output int waited);
        grant_t e;
        wait_node_req(waited);
        if (bus.NODE_REQ !== 1'b1) return;
        if (grant_q.size() == 0) begin
            chk("grant_queue_empty", 64'(grant_q.size()), 64'd1);
            return;
        end
        e = grant_q.pop_front();
        drive_req_bus(1'b1);
        @(negedge CLK);
        chk("node_addr", 64'(bus.NODE_ADDR), 64'(e.addr));
        chk("node_data", 64'(bus.NODE_DATA), 64'(e.data));
        chk("node_req_hold", 64'(bus.NODE_REQ), 64'd1);
        drive_req_bus(1'b0);
        bus.NODE_ACK = 1'b1;
        @(negedge CLK);
        chk("req_ack", 64'(bus.REQ_ACK), 64'd1 << e.id);
        chk("node_req_drop", 64'(bus.NODE_REQ), 64'd0);
        done_q.push_back(e.id);
        bus.NODE_ACK = 1'b0;
        bus.REQ_VALID[e.id] = 1'b0;
        @(negedge CLK);
        chk("req_ack_release", 64'(bus.REQ_ACK), 64'd0);
        if (keep) bus.REQ_VALID[e.id] = 1'b1;
    endtask

    task automatic issue_single(input int id);
        int w;
        bus.REQ_VALID = 4'b0001 << id;
        expect_grant(id);
        serve_issue(1'b0, w);
    endtask

    task automatic complete(input logic succ, input logic fail);
        logic [1:0] id;
        if (done_q.size() == 0) begin
            chk("done_queue_empty", 64'(done_q.size()), 64'd1);
            return;
        end
        id = done_q.pop_front();
        bus.NODE_TX_SUCCESS = succ;
        bus.NODE_TX_FAIL    = fail;
        @(negedge CLK);
        chk("done_success", 64'(bus.DONE_SUCCESS), fail ? 64'd0 : (64'd1 << id));
        chk("done_fail", 64'(bus.DONE_FAIL), fail ? (64'd1 << id) : 64'd0);
        chk("tx_ack_wait", 64'(bus.NODE_TX_ACK), 64'd0);
        bus.DONE_ACK[id] = 1'b1;
        @(negedge CLK);
        chk("done_clear", 64'({bus.DONE_SUCCESS, bus.DONE_FAIL}), 64'd0);
        chk("tx_ack_set", 64'(bus.NODE_TX_ACK), 64'd1);
        bus.DONE_ACK        = '0;
        bus.NODE_TX_SUCCESS = 1'b0;
        bus.NODE_TX_FAIL    = 1'b0;
        @(negedge CLK);
        chk("tx_ack_release", 64'(bus.NODE_TX_ACK), 64'd0);
    endtask

    task automatic pulse_reset();
        RESET = 1'b0;
        @(negedge CLK);
        chk("reset_outputs", all_outputs(), 64'd0);
        grant_q.delete();
        done_q.delete();
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [1:0] dummy;

        tbl[0] = '{4'b0100, 2'd2, 8'h5A, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{4'b0011, 2'd0, 8'h10, 32'hC0DE0000, 1'b0};
        tbl[2] = '{4'b0011, 2'd1, 8'h11, 32'hC0DE0001, 1'b1};
        tbl[3] = '{4'b1001, 2'd3, 8'h13, 32'hC0DE0003, 1'b0};
        tbl[4] = '{4'b1000, 2'd3, 8'h13, 32'hC0DE0003, 1'b1};
        tbl[5] = '{4'b0110, 2'd1, 8'h11, 32'hC0DE0001, 1'b0};

        bus.REQ_VALID       = '0;
        bus.NODE_ACK        = 1'b0;
        bus.NODE_TX_SUCCESS = 1'b0;
        bus.NODE_TX_FAIL    = 1'b0;
        bus.DONE_ACK        = '0;
        drive_req_bus(1'b0);
        repeat (3) @(negedge CLK);
        chk("reset_outputs", all_outputs(), 64'd0);
        RESET = 1'b1;
        @(negedge CLK);

        // Vector table: one grant and one completion per row, RR pointer carried between rows.
        for (int unsigned r = 0; r < 6; r++) begin
            bus.REQ_VALID = tbl[r].valid;
            grant_q.push_back('{tbl[r].exp_id, tbl[r].exp_addr, tbl[r].exp_data});
            serve_issue(1'b0, w);
            chk("grant_latency", 64'(w), 64'd1);
            bus.REQ_VALID = '0;
            chk("in_flight_one", 64'(bus.IN_FLIGHT), 64'd1);
            complete(!tbl[r].fail, tbl[r].fail);
            chk("in_flight_zero", 64'(bus.IN_FLIGHT), 64'd0);
        end

        // All requesters held high: grants 0,1,2,3,0 after reset.
        pulse_reset();
        bus.REQ_VALID = '1;
        expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
        for (int unsigned i = 0; i < 5; i++) serve_issue(1'b1, w);
        bus.REQ_VALID = '0;
        chk("rr_in_flight", 64'(bus.IN_FLIGHT), 64'd5);
        complete(1'b1, 1'b0); complete(1'b0, 1'b1); complete(1'b1, 1'b0);
        complete(1'b1, 1'b0); complete(1'b1, 1'b0);

        // Completions routed in issue order 0,2,1; FAIL wins when both are high.
        issue_single(0); issue_single(2); issue_single(1);
        complete(1'b1, 1'b0); complete(1'b1, 1'b1); complete(1'b1, 1'b0);

        // FIFO full blocks grants until a completion frees an entry.
        for (int i = 0; i < DEP; i++) issue_single(i % NR);
        chk("fifo_full_in_flight", 64'(bus.IN_FLIGHT), 64'd8);
        bus.REQ_VALID = 4'b0010;
        expect_grant(1);
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("blocked_node_req", 64'(bus.NODE_REQ), 64'd0);
        end
        complete(1'b1, 1'b0);
        serve_issue(1'b0, w);
        chk("refill_in_flight", 64'(bus.IN_FLIGHT), 64'd8);
        for (int i = 0; i < DEP; i++) complete(1'b1, 1'b0);
        chk("drained_in_flight", 64'(bus.IN_FLIGHT), 64'd0);

        // Orphan completion with the FIFO empty.
        bus.NODE_TX_SUCCESS = 1'b1;
        @(negedge CLK);
        chk("orphan_flag", 64'(bus.ERR_ORPHAN), 64'd1);
        chk("orphan_tx_ack", 64'(bus.NODE_TX_ACK), 64'd1);
        chk("orphan_no_done", 64'({bus.DONE_SUCCESS, bus.DONE_FAIL}), 64'd0);
        bus.NODE_TX_SUCCESS = 1'b0;
        @(negedge CLK);
        chk("orphan_tx_release", 64'(bus.NODE_TX_ACK), 64'd0);
        chk("orphan_sticky", 64'(bus.ERR_ORPHAN), 64'd1);

        // Push and pop on the same edge keep occupancy.
        issue_single(2);
        bus.REQ_VALID = 4'b1000;
        wait_node_req(w);
        chk("pp_node_addr", 64'(bus.NODE_ADDR), 64'(addr_of(3)));
        bus.NODE_ACK        = 1'b1;
        bus.NODE_TX_SUCCESS = 1'b1;
        @(negedge CLK);
        chk("pp_in_flight", 64'(bus.IN_FLIGHT), 64'd1);
        chk("pp_req_ack", 64'(bus.REQ_ACK), 64'b1000);
        chk("pp_done_success", 64'(bus.DONE_SUCCESS), 64'b0100);
        bus.DONE_ACK[2] = 1'b1;
        bus.NODE_ACK    = 1'b0;
        bus.REQ_VALID   = '0;
        @(negedge CLK);
        chk("pp_req_ack_release", 64'(bus.REQ_ACK), 64'd0);
        chk("pp_tx_ack", 64'(bus.NODE_TX_ACK), 64'd1);
        bus.DONE_ACK        = '0;
        bus.NODE_TX_SUCCESS = 1'b0;
        @(negedge CLK);
        chk("pp_tx_release", 64'(bus.NODE_TX_ACK), 64'd0);
        dummy = done_q.pop_front();
        done_q.push_back(2'd3);
        complete(1'b0, 1'b1);
        chk("pp_in_flight_end", 64'(bus.IN_FLIGHT), 64'd0);

        // Asynchronous reset while issue is in I_ISSUE and completion is in C_WAIT.
        issue_single(1);
        bus.REQ_VALID = 4'b0100;
        wait_node_req(w);
        bus.NODE_TX_FAIL = 1'b1;
        @(negedge CLK);
        chk("mid_done_fail", 64'(bus.DONE_FAIL), 64'b0010);
        chk("mid_node_req", 64'(bus.NODE_REQ), 64'd1);
        #2 RESET = 1'b0;
        #1 chk("async_reset_outputs", all_outputs(), 64'd0);
        bus.REQ_VALID    = '0;
        bus.NODE_TX_FAIL = 1'b0;
        grant_q.delete();
        done_q.delete();
        @(negedge CLK);
        RESET = 1'b1;
        bus.REQ_VALID = '1;
        expect_grant(0);
        serve_issue(1'b0, w);
        chk("post_reset_latency", 64'(w), 64'd1);
        bus.REQ_VALID = '0;
        complete(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
